// File: rtl/rv32imf_wake_unit_pkg.sv
// Shared types for the wake unit: FSM state encoding and wake counter width.
package rv32imf_pkg;

  typedef enum logic [1:0] {
    WAKE_RUN,
    WAKE_SLEEP,
    WAKE_WAKE
  } wake_state_e;

  localparam int WAKE_CNT_W = 16;

endpackage

// File: rtl/rv32imf_wake_unit_if.sv
// Event/wake bundle between the core-side environment (master) and the wake unit (slave).
interface rv32imf_wake_unit_if #(
  parameter int NUM_EVENTS = 8
);
  import rv32imf_pkg::*;

  localparam int ID_W = $clog2(NUM_EVENTS);

  // ev_ack_i works as ready against event_valid_o: a pending bit retires only on a cycle
  // where both are high, and an ack with event_valid_o low has no effect.
  logic                  core_sleep_i;
  logic [NUM_EVENTS-1:0] event_i;
  logic                  mask_we_i;
  logic [NUM_EVENTS-1:0] mask_wdata_i;
  logic                  ev_ack_i;
  logic                  wake_from_sleep_o;
  logic                  pulp_clock_en_o;
  logic                  event_valid_o;
  logic [ID_W-1:0]       event_id_o;
  logic [NUM_EVENTS-1:0] mask_o;
  logic [WAKE_CNT_W-1:0] wake_count_o;
  wake_state_e           state;

  modport master (
    output core_sleep_i, event_i, mask_we_i, mask_wdata_i, ev_ack_i,
    input  wake_from_sleep_o, pulp_clock_en_o, event_valid_o, event_id_o,
    input  mask_o, wake_count_o, state
  );

  modport slave (
    input  core_sleep_i, event_i, mask_we_i, mask_wdata_i, ev_ack_i,
    output wake_from_sleep_o, pulp_clock_en_o, event_valid_o, event_id_o,
    output mask_o, wake_count_o, state
  );

endinterface

// File: rtl/rv32imf_wake_unit_prio_enc.sv
// Combinational lowest-index-first priority encoder.
module rv32imf_event_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0]         req,
  output logic                 valid,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  always_comb begin
    valid = |req;
    idx   = '0;
    // Scan downward so the lowest set index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/rv32imf_wake_unit.sv
// Wake unit: pending/masked event tracking and RUN/SLEEP/WAKE control of wake and clock enable.
// Optional wake-up counter enabled by defining RV32IMF_WAKE_COUNTER_EN.
module rv32imf_wake_unit
  import rv32imf_pkg::*;
#(
  parameter int NUM_EVENTS = 8,
  parameter int WAKE_DELAY = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  rv32imf_wake_unit_if.slave bus
);

  localparam int ID_W  = $clog2(NUM_EVENTS);
  localparam int CNT_W = $clog2(WAKE_DELAY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAKE_DELAY - 1);

  logic [NUM_EVENTS-1:0] pending_q;
  logic [NUM_EVENTS-1:0] mask_q;
  logic [NUM_EVENTS-1:0] live;
  logic [NUM_EVENTS-1:0] clr;
  logic [ID_W-1:0]       event_id;
  logic                  wake_req;
  logic                  enter_wake;
  logic [CNT_W-1:0]      cnt_q;
  logic                  wake_q;
  logic                  clk_en_q;
  wake_state_e           state_q;

  assign live = pending_q & mask_q;

  rv32imf_event_prio_enc #(.N(NUM_EVENTS)) u_prio_enc (
    .req   (live),
    .valid (wake_req),
    .idx   (event_id)
  );

  assign clr        = (bus.ev_ack_i && wake_req) ? (NUM_EVENTS'(1) << event_id) : '0;
  assign enter_wake = wake_req && ((state_q == WAKE_SLEEP) ||
                                   ((state_q == WAKE_RUN) && bus.core_sleep_i));

  // Setting is applied after clearing so a re-asserted event survives its own ack.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
      mask_q    <= '1;
    end else begin
      pending_q <= (pending_q & ~clr) | bus.event_i;
      if (bus.mask_we_i) mask_q <= bus.mask_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= WAKE_RUN;
      cnt_q    <= '0;
      wake_q   <= 1'b0;
      clk_en_q <= 1'b1;
    end else begin
      case (state_q)
        WAKE_RUN, WAKE_SLEEP: begin
          if (enter_wake) begin
            state_q  <= WAKE_WAKE;
            cnt_q    <= CNT_LOAD;
            wake_q   <= 1'b1;
            clk_en_q <= 1'b1;
          end else if (state_q == WAKE_RUN && bus.core_sleep_i) begin
            state_q  <= WAKE_SLEEP;
            wake_q   <= 1'b0;
            clk_en_q <= 1'b0;
          end
        end
        WAKE_WAKE: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          // Wake stays asserted while the core still reports sleep, past the minimum hold.
          if (cnt_q == '0 && !bus.core_sleep_i) begin
            state_q  <= WAKE_RUN;
            wake_q   <= 1'b0;
            clk_en_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= WAKE_RUN;
          wake_q   <= 1'b0;
          clk_en_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef RV32IMF_WAKE_COUNTER_EN
  logic [WAKE_CNT_W-1:0] wake_count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) wake_count_q <= '0;
    else if (enter_wake) wake_count_q <= wake_count_q + 1'b1;
  end

  assign bus.wake_count_o = wake_count_q;
`else
  assign bus.wake_count_o = '0;
`endif

  assign bus.wake_from_sleep_o = wake_q;
  assign bus.pulp_clock_en_o   = clk_en_q;
  assign bus.event_valid_o     = wake_req;
  assign bus.event_id_o        = event_id;
  assign bus.mask_o            = mask_q;
  assign bus.state             = state_q;

endmodule
